// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Issues each accepted request for one cycle and returns a registered, ID-tagged response.
module alu_arbiter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [3:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [3:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic [3:0]   alu_op,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_result,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_data,
  output logic         rsp_taken,
  output logic         rsp_err
);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_BEQ = 4'h8;
  localparam logic [3:0] OP_BNE = 4'h9;
  localparam logic [3:0] OP_BLT = 4'hA;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t       state, state_nxt;
  logic         last_grant;
  logic         grant_valid;
  logic         grant_id;
  logic         iss_id;
  logic [3:0]   iss_op;
  logic [3:0]   op_sel;
  logic [W-1:0] a_sel;
  logic [W-1:0] b_sel;
  logic         sel_branch;
  logic         iss_illegal;
  logic         taken_c;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req0_valid || req1_valid) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant decode: ties go to the port that did not win last time
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (state == IDLE) begin
      grant_valid = req0_valid || req1_valid;
      grant_id    = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    end
    req0_ready = grant_valid && !grant_id;
    req1_ready = grant_valid && grant_id;
  end

  always_comb begin
    op_sel     = grant_id ? req1_op : req0_op;
    a_sel      = grant_id ? req1_a  : req0_a;
    b_sel      = grant_id ? req1_b  : req0_b;
    sel_branch = (op_sel == OP_BEQ) || (op_sel == OP_BNE) || (op_sel == OP_BLT);
  end

  // Branch resolution from the issued operands, independent of the ALU
  always_comb begin
    iss_illegal = (iss_op > OP_BLT);
    case (iss_op)
      OP_BEQ:  taken_c = (alu_a == alu_b);
      OP_BNE:  taken_c = (alu_a != alu_b);
      OP_BLT:  taken_c = ($signed(alu_a) < $signed(alu_b));
      default: taken_c = 1'b0;
    endcase
  end

  // Issue registers double as the held ALU drive; response captured leaving EXEC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
      iss_id     <= 1'b0;
      iss_op     <= OP_ADD;
      alu_op     <= OP_ADD;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      rsp_taken  <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      rsp_valid <= (state_nxt == RESP);
      if (grant_valid) begin
        last_grant <= grant_id;
        iss_id     <= grant_id;
        iss_op     <= op_sel;
        alu_op     <= sel_branch ? OP_SUB : op_sel;
        alu_a      <= a_sel;
        alu_b      <= b_sel;
      end
      if (state == EXEC) begin
        rsp_id    <= iss_id;
        rsp_data  <= iss_illegal ? '0 : alu_result;
        rsp_taken <= taken_c;
        rsp_err   <= iss_illegal;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU on the alu_* port.
// Expected responses are queued at each accept and popped when the DUT responds.
module tb_alu_arbiter;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic         id;
    logic [W-1:0] data;
    logic         taken;
    logic         err;
  } rsp_t;

  logic         clk, reset;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]   req0_op, req1_op, alu_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_result;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_taken, rsp_err;
  logic [W-1:0] rsp_data;

  rsp_t q[$];
  int   total = 0;
  int   bad   = 0;

  alu_arbiter #(.W(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_taken(rsp_taken), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU; unknown codes (including branch codes) return a marker value
  function automatic logic [W-1:0] alu_f(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'h5: return a << b[2:0];
      4'h6: return a >> b[2:0];
      4'h7: return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      default: return 8'h5A;
    endcase
  endfunction

  assign alu_result = alu_f(alu_op, alu_a, alu_b);

  function automatic rsp_t exp_f(input logic id, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    rsp_t r;
    r.id    = id;
    r.err   = (op >= 4'hB);
    r.taken = 1'b0;
    if (r.err) r.data = '0;
    else if (op >= 4'h8) r.data = a - b;
    else r.data = alu_f(op, a, b);
    if (op == 4'h8) r.taken = (a == b);
    if (op == 4'h9) r.taken = (a != b);
    if (op == 4'hA) r.taken = ($signed(a) < $signed(b));
    return r;
  endfunction

  function automatic rsp_t observed();
    rsp_t r;
    r = {rsp_id, rsp_data, rsp_taken, rsp_err};
    return r;
  endfunction

  // Drive one request, queue its expected response, and capture what the DUT shows per phase
  task automatic run_op(input logic port, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output bit accepted, output logic [3:0] ex_op, output logic [W-1:0] ex_a,
                        output logic [W-1:0] ex_b, output logic v_k1, output rsp_t got, output logic v_after);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    if (port) begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
    else      begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
    #1;
    accepted = 1'b0;
    ex_op = '0; ex_a = '0; ex_b = '0; v_k1 = 1'b0; got = '0; v_after = 1'b0;
    for (int i = 0; i < 20 && !accepted; i++) begin
      if ((port ? req1_ready : req0_ready) === 1'b1) accepted = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (accepted) q.push_back(exp_f(port, op, a, b));
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    ex_op = alu_op; ex_a = alu_a; ex_b = alu_b;
    @(posedge clk); #1;
    v_k1 = rsp_valid; got = observed();
    @(posedge clk); #1;
    v_after = rsp_valid;
  endtask

  task automatic test_reset();
    reset = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    total++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_taken, rsp_err} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      bad++; $display("FAIL reset_rsp got=%h want=%h", {rsp_valid, rsp_id, rsp_data, rsp_taken, rsp_err}, 12'h000);
    end
    total++;
    if ({alu_op, alu_a, alu_b} !== 20'h0) begin
      bad++; $display("FAIL reset_alu got=%h want=00000", {alu_op, alu_a, alu_b});
    end
    total++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      bad++; $display("FAIL reset_ready got=%b want=00", {req0_ready, req1_ready});
    end
  endtask

  task automatic load0(input int k);
    req0_op = 4'h0; req0_a = W'(k * 16 + 1); req0_b = 8'h22;
  endtask

  task automatic load1(input int k);
    req1_op = 4'h4; req1_a = 8'hA5; req1_b = W'(k);
  endtask

  task automatic test_tie();
    int n0 = 0, n1 = 0, cyc = 0, nrsp = 0;
    logic g0, g1, exp_g, win;
    rsp_t e;
    exp_g = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; load0(0); load1(0);
    while ((n0 < 4 || n1 < 4 || q.size() > 0) && cyc < 200) begin
      #1;
      if (rsp_valid === 1'b1) begin
        total++; nrsp++;
        if (q.size() == 0) begin
          bad++; $display("FAIL tie_rsp_unexpected got=%h want=none", observed());
        end else begin
          e = q.pop_front();
          if (observed() !== e) begin bad++; $display("FAIL tie_rsp got=%h want=%h", observed(), e); end
        end
      end
      g0 = req0_ready; g1 = req1_ready;
      if (g0 || g1) begin
        win = (req0_valid && req1_valid) ? exp_g : req1_valid;
        total++;
        if ({g0, g1} !== (win ? 2'b01 : 2'b10)) begin
          bad++; $display("FAIL tie_grant got=%b want=%b", {g0, g1}, win ? 2'b01 : 2'b10);
        end
        if (g1) q.push_back(exp_f(1'b1, req1_op, req1_a, req1_b));
        else    q.push_back(exp_f(1'b0, req0_op, req0_a, req0_b));
        exp_g = ~g1;
      end
      @(posedge clk); #1; cyc++;
      if (g0 && !g1) begin n0++; if (n0 == 4) req0_valid = 1'b0; else load0(n0); end
      if (g1) begin n1++; if (n1 == 4) req1_valid = 1'b0; else load1(n1); end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    total++;
    if (cyc >= 200 || nrsp != 8) begin
      bad++; $display("FAIL tie_count got=%0d want=8 cycles=%0d", nrsp, cyc);
    end
    q.delete();
  endtask

  task automatic test_single();
    bit acc; logic [3:0] xo; logic [W-1:0] xa, xb; logic vk, va; rsp_t got, e;
    run_op(1'b0, 4'h0, 8'h7F, 8'h01, acc, xo, xa, xb, vk, got, va);
    total++;
    if (!acc) begin bad++; $display("FAIL single_accept got=0 want=1"); end
    else begin
      e = q.pop_front();
      total++;
      if ({xo, xa, xb} !== {4'h0, 8'h7F, 8'h01}) begin bad++; $display("FAIL single_exec got=%h want=07f01", {xo, xa, xb}); end
      total++;
      if (vk !== 1'b1 || got !== e) begin bad++; $display("FAIL single_rsp valid=%b got=%h want=%h", vk, got, e); end
      total++;
      if (got.data !== 8'h80) begin bad++; $display("FAIL single_data got=%h want=80", got.data); end
      total++;
      if (va !== 1'b0) begin bad++; $display("FAIL single_release got=%b want=0", va); end
    end
  endtask

  task automatic test_branch();
    logic [3:0] ops [4] = '{4'hA, 4'h8, 4'h9, 4'h7};
    logic [W-1:0] as [4] = '{8'hFE, 8'h05, 8'h05, 8'hFE};
    logic [W-1:0] bs [4] = '{8'h01, 8'h05, 8'h05, 8'h01};
    bit acc; logic [3:0] xo, want_op; logic [W-1:0] xa, xb; logic vk, va; rsp_t got, e;
    for (int i = 0; i < 4; i++) begin
      run_op(1'b1, ops[i], as[i], bs[i], acc, xo, xa, xb, vk, got, va);
      total++;
      if (!acc) begin bad++; $display("FAIL branch_accept op=%h got=0 want=1", ops[i]); end
      else begin
        e = q.pop_front();
        want_op = (ops[i] >= 4'h8) ? 4'h1 : ops[i];
        total++;
        if (xo !== want_op) begin bad++; $display("FAIL branch_aluop op=%h got=%h want=%h", ops[i], xo, want_op); end
        total++;
        if (vk !== 1'b1 || got !== e) begin bad++; $display("FAIL branch_rsp op=%h got=%h want=%h", ops[i], got, e); end
      end
    end
  endtask

  task automatic test_illegal();
    bit acc; logic [3:0] xo; logic [W-1:0] xa, xb; logic vk, va; rsp_t got, e;
    run_op(1'b0, 4'hC, 8'h01, 8'h01, acc, xo, xa, xb, vk, got, va);
    total++;
    if (!acc) begin bad++; $display("FAIL illegal_accept got=0 want=1"); end
    else begin
      e = q.pop_front();
      total++;
      if (xo !== 4'hC) begin bad++; $display("FAIL illegal_aluop got=%h want=c", xo); end
      total++;
      if (vk !== 1'b1 || got !== e || got.err !== 1'b1) begin bad++; $display("FAIL illegal_rsp got=%h want=%h", got, e); end
    end
  endtask

  task automatic test_backpressure();
    rsp_t e;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 4'h1; req0_a = 8'h03; req0_b = 8'h05;
    #1;
    total++;
    if (req0_ready !== 1'b1) begin bad++; $display("FAIL bp_accept got=%b want=1", req0_ready); end
    e = exp_f(1'b0, 4'h1, 8'h03, 8'h05);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = 4'h0; req1_a = 8'h01; req1_b = 8'h02;
    #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b00) begin bad++; $display("FAIL bp_exec_ready got=%b want=00", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({rsp_valid, rsp_data, req0_ready, req1_ready} !== {1'b1, 8'hFE, 2'b00}) begin
        bad++; $display("FAIL bp_hold cyc=%0d got=%h want=%h", i, {rsp_valid, rsp_data, req0_ready, req1_ready}, {1'b1, 8'hFE, 2'b00});
      end
      @(posedge clk); #1;
    end
    total++;
    if (observed() !== e) begin bad++; $display("FAIL bp_rsp got=%h want=%h", observed(), e); end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({rsp_valid, req1_ready} !== 2'b01) begin bad++; $display("FAIL bp_release got=%b want=01", {rsp_valid, req1_ready}); end
    req1_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop();
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 4'h0; req0_a = 8'h10; req0_b = 8'h20;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    total++;
    if (alu_a !== 8'h10) begin bad++; $display("FAIL midop_exec got=%h want=10", alu_a); end
    #1 reset = 1'b1;
    #1;
    total++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_taken, rsp_err, alu_op, alu_a, alu_b} !== 32'h0) begin
      bad++; $display("FAIL midop_reset got=%h want=0", {rsp_valid, rsp_id, rsp_data, rsp_taken, rsp_err, alu_op, alu_a, alu_b});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL midop_norsp got=%b want=0", rsp_valid); end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL midop_tie got=%b want=10", {req0_ready, req1_ready}); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_tie();
    test_single();
    test_branch();
    test_illegal();
    test_backpressure();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
